bus_drvr_fifo_bank: RTL and testbench
=====================================

Name: bus_drvr_fifo_bank

Overview:
Parametrised bank of BITS×DRVRS independent packet FIFOs, one per (bus, driver) pair. Models the driver-side queues feeding the bus under test. The agent side pushes packets in. The bus side sees pndng / D_pop and pops packets. This generation adds configurable depth, a full-handling mode (drop-new or overwrite-oldest), per-channel occupancy and per-channel saturating drop counters.

Parameters:
BITS, 1, number of buses
DRVRS, 4, drivers per bus
PCKG_SZ, 16, packet width in bits
DEPTH, 8, entries per FIFO (>=2, any integer; pointers wrap at DEPTH-1)
OVF_MODE, 0, 0 = drop incoming packet when full, 1 = overwrite oldest packet when full
CNT_W, 8, width of each drop counter

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-high reset
push  in  BITS*DRVRS  per-channel write strobe, channel ch = b*DRVRS + d
D_push  in  BITS*DRVRS*PCKG_SZ  write data, channel ch at bits [ch*PCKG_SZ +: PCKG_SZ]
pop  in  BITS*DRVRS  per-channel read strobe from bus side
D_pop  out  BITS*DRVRS*PCKG_SZ  head-of-queue data, same packing as D_push
pndng  out  BITS*DRVRS  channel non-empty
full  out  BITS*DRVRS  channel holds DEPTH entries
count  out  BITS*DRVRS*$clog2(DEPTH+1)  per-channel occupancy, packed like D_pop
drop_cnt  out  BITS*DRVRS*CNT_W  per-channel count of lost packets, packed like D_pop

Behaviour:
- Reset (async assert, sync-safe release): all rd/wr pointers, count, drop_cnt = 0; pndng = 0; full = 0; D_pop = 0. Storage array is not reset; its contents are never visible while empty.
- Channels are fully independent. No shared state and no arbitration between channels.
- Show-ahead read: D_pop[ch] = entry at rd pointer whenever pndng[ch] = 1, else D_pop[ch] = 0 (combinational from registered state).
- Write latency: a packet pushed at edge N is visible on D_pop/pndng after edge N (0 extra cycles). No same-cycle bypass into an empty FIFO.
- pndng = (count != 0); full = (count == DEPTH); both derived from registered count.
- Per-edge update for one channel, with p = push, q = pop:
  - p=0, q=0: no change.
  - p=1, not full: write D_push at wr pointer, wr pointer +1 (wraps), count +1.
  - q=1, pndng=1: rd pointer +1 (wraps), count -1.
  - q=1, empty: ignored. No pointer change. No error flag.
  - p=1, q=1, 0<count<DEPTH: both occur, count unchanged.
  - p=1, q=1, empty: push only. count becomes 1. The pop is ignored.
  - p=1, q=1, full: both occur. count stays DEPTH. Not a drop.
  - p=1, q=0, full, OVF_MODE=0: packet discarded. Pointers and count unchanged. drop_cnt +1.
  - p=1, q=0, full, OVF_MODE=1: write at wr pointer. wr and rd pointers both +1, so the oldest entry is lost. count stays DEPTH. drop_cnt +1.
- drop_cnt saturates at 2^CNT_W-1; it does not wrap.
- Reset asserted mid-operation: all state clears immediately (async), and queued packets are discarded. The first push after release is accepted normally.
- Width rules: pointers are $clog2(DEPTH) bits, with explicit wrap compare to DEPTH-1 (non-power-of-2 DEPTH must work). count is $clog2(DEPTH+1) bits.

Test Plan:
- Basic order, ch0, DEPTH=8: push 0x0001..0x0005 on 5 consecutive cycles, then pop 5 cycles -> D_pop[ch0] reads 0x0001..0x0005 in order; count goes 5→0; pndng drops after the 5th pop; other channels stay pndng=0.
- Drop mode, OVF_MODE=0: push 10 packets 0xA000..0xA009 into ch3 with no pops -> full=1 after the 8th; count=8; drop_cnt[ch3]=2; draining yields 0xA000..0xA007.
- Overwrite mode, OVF_MODE=1: same stimulus as drop mode -> drop_cnt[ch3]=2; draining yields 0xA002..0xA009.
- Simultaneous edges: on ch1, push+pop while empty gives count=1 and pops nothing. Push+pop while full gives count=8, drop_cnt unchanged, and the head advances by one. Pop while empty leaves count=0.
- Saturation and independence, CNT_W=2, BITS=2: hold push on ch5 while full for 6 cycles -> drop_cnt[ch5]=3 and stays 3; all other channels unaffected.
- Async reset: with ch0 count=4, assert reset between clock edges -> pndng, count, D_pop and drop_cnt read 0 before the next edge. After release, push 0xBEEF gives D_pop[ch0]=0xBEEF and count=1.

Source files
------------

// File: rtl/bus_drvr_fifo_bank.sv
// rtl/bus_drvr_fifo_bank.sv - bank of BITS*DRVRS independent show-ahead packet FIFOs
// Each channel supports drop-new or overwrite-oldest on full, with a saturating drop counter.
module bus_drvr_fifo_bank #(
  parameter int BITS     = 1,
  parameter int DRVRS    = 4,
  parameter int PCKG_SZ  = 16,
  parameter int DEPTH    = 8,
  parameter int OVF_MODE = 0,
  parameter int CNT_W    = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [BITS*DRVRS-1:0]                     push,
  input  logic [BITS*DRVRS*PCKG_SZ-1:0]             D_push,
  input  logic [BITS*DRVRS-1:0]                     pop,
  output logic [BITS*DRVRS*PCKG_SZ-1:0]             D_pop,
  output logic [BITS*DRVRS-1:0]                     pndng,
  output logic [BITS*DRVRS-1:0]                     full,
  output logic [BITS*DRVRS*$clog2(DEPTH+1)-1:0]     count,
  output logic [BITS*DRVRS*CNT_W-1:0]               drop_cnt
);

  localparam int NCH   = BITS * DRVRS;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  logic [PCKG_SZ-1:0] mem_q [NCH][DEPTH];

  logic [PTR_W-1:0] rd_ptr_q [NCH];
  logic [PTR_W-1:0] rd_ptr_d [NCH];
  logic [PTR_W-1:0] wr_ptr_q [NCH];
  logic [PTR_W-1:0] wr_ptr_d [NCH];
  logic [CW-1:0]    cnt_q    [NCH];
  logic [CW-1:0]    cnt_d    [NCH];
  logic [CNT_W-1:0] drop_q   [NCH];
  logic [CNT_W-1:0] drop_d   [NCH];
  logic [NCH-1:0]   wr_en;

  // Explicit wrap so non-power-of-two depths cycle correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      logic is_full;
      logic is_empty;
      logic do_push;
      logic do_pop;
      logic do_drop;

      rd_ptr_d[ch] = rd_ptr_q[ch];
      wr_ptr_d[ch] = wr_ptr_q[ch];
      cnt_d[ch]    = cnt_q[ch];
      drop_d[ch]   = drop_q[ch];
      wr_en[ch]    = 1'b0;

      is_full  = (cnt_q[ch] == CW'(DEPTH));
      is_empty = (cnt_q[ch] == '0);
      do_drop  = push[ch] && !pop[ch] && is_full;
      do_push  = push[ch] && (!is_full || pop[ch] || (OVF_MODE != 0));
      // Overwrite mode retires the oldest entry to make room for the new one.
      do_pop   = (pop[ch] && !is_empty) || (do_drop && (OVF_MODE != 0));

      if (do_push) begin
        wr_en[ch]    = 1'b1;
        wr_ptr_d[ch] = ptr_inc(wr_ptr_q[ch]);
      end
      if (do_pop) begin
        rd_ptr_d[ch] = ptr_inc(rd_ptr_q[ch]);
      end
      if (do_push && !do_pop) begin
        cnt_d[ch] = cnt_q[ch] + CW'(1);
      end else if (do_pop && !do_push) begin
        cnt_d[ch] = cnt_q[ch] - CW'(1);
      end
      if (do_drop && (drop_q[ch] != {CNT_W{1'b1}})) begin
        drop_d[ch] = drop_q[ch] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < NCH; ch++) begin
        rd_ptr_q[ch] <= '0;
        wr_ptr_q[ch] <= '0;
        cnt_q[ch]    <= '0;
        drop_q[ch]   <= '0;
      end
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        rd_ptr_q[ch] <= rd_ptr_d[ch];
        wr_ptr_q[ch] <= wr_ptr_d[ch];
        cnt_q[ch]    <= cnt_d[ch];
        drop_q[ch]   <= drop_d[ch];
      end
    end
  end

  // Storage is never visible while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < NCH; ch++) begin
      if (wr_en[ch]) begin
        mem_q[ch][wr_ptr_q[ch]] <= D_push[ch*PCKG_SZ +: PCKG_SZ];
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign pndng[g]                      = (cnt_q[g] != '0);
    assign full[g]                       = (cnt_q[g] == CW'(DEPTH));
    assign D_pop[g*PCKG_SZ +: PCKG_SZ]   = pndng[g] ? mem_q[g][rd_ptr_q[g]] : '0;
    assign count[g*CW +: CW]             = cnt_q[g];
    assign drop_cnt[g*CNT_W +: CNT_W]    = drop_q[g];
  end

endmodule

// File: tb/tb_bus_drvr_fifo_bank.sv
// tb/tb_bus_drvr_fifo_bank.sv - self-checking bench for bus_drvr_fifo_bank
// Three instances share stimulus: drop/depth 8, overwrite/depth 8, overwrite/depth 5.
module tb_bus_drvr_fifo_bank;

  localparam int NCH = 8;
  localparam int PW  = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [NCH-1:0] push = '0;
  logic [NCH-1:0] pop = '0;
  logic [NCH*PW-1:0] d_push = '0;

  logic [NCH*PW-1:0] dpop0, dpop1, dpop2;
  logic [NCH-1:0]    pnd0, pnd1, pnd2, full0, full1, full2;
  logic [NCH*4-1:0]  cnt0, cnt1;
  logic [NCH*3-1:0]  cnt2;
  logic [NCH*2-1:0]  drop0, drop1, drop2;

  bus_drvr_fifo_bank #(.BITS(2), .DRVRS(4), .PCKG_SZ(16), .DEPTH(8), .OVF_MODE(0), .CNT_W(2)) u0 (
    .clk(clk), .reset(reset), .push(push), .D_push(d_push), .pop(pop),
    .D_pop(dpop0), .pndng(pnd0), .full(full0), .count(cnt0), .drop_cnt(drop0));
  bus_drvr_fifo_bank #(.BITS(2), .DRVRS(4), .PCKG_SZ(16), .DEPTH(8), .OVF_MODE(1), .CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .push(push), .D_push(d_push), .pop(pop),
    .D_pop(dpop1), .pndng(pnd1), .full(full1), .count(cnt1), .drop_cnt(drop1));
  bus_drvr_fifo_bank #(.BITS(2), .DRVRS(4), .PCKG_SZ(16), .DEPTH(5), .OVF_MODE(1), .CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .push(push), .D_push(d_push), .pop(pop),
    .D_pop(dpop2), .pndng(pnd2), .full(full2), .count(cnt2), .drop_cnt(drop2));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int depth [3] = '{8, 8, 5};
  int ovf   [3] = '{0, 1, 1};
  logic [15:0] mq [3][NCH][$];
  int md [3][NCH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < NCH; c++) begin
        mq[i][c].delete();
        md[i][c] = 0;
      end
  endtask

  task automatic model_edge(input logic [NCH-1:0] p, input logic [NCH-1:0] q, input logic [NCH*PW-1:0] d);
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < NCH; c++) begin
        int sz;
        logic [15:0] v;
        sz = mq[i][c].size();
        v = d[c*PW +: PW];
        if (p[c] && q[c]) begin
          if (sz != 0) void'(mq[i][c].pop_front());
          mq[i][c].push_back(v);
        end else if (p[c]) begin
          if (sz < depth[i]) mq[i][c].push_back(v);
          else begin
            if (md[i][c] < 3) md[i][c]++;
            if (ovf[i] != 0) begin
              void'(mq[i][c].pop_front());
              mq[i][c].push_back(v);
            end
          end
        end else if (q[c]) begin
          if (sz != 0) void'(mq[i][c].pop_front());
        end
      end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < NCH; c++) begin
        logic [15:0] od;
        logic op, of;
        logic [3:0] oc;
        logic [1:0] odr;
        int sz;
        case (i)
          0: begin od = dpop0[c*PW +: PW]; op = pnd0[c]; of = full0[c]; oc = cnt0[c*4 +: 4]; odr = drop0[c*2 +: 2]; end
          1: begin od = dpop1[c*PW +: PW]; op = pnd1[c]; of = full1[c]; oc = cnt1[c*4 +: 4]; odr = drop1[c*2 +: 2]; end
          default: begin od = dpop2[c*PW +: PW]; op = pnd2[c]; of = full2[c]; oc = {1'b0, cnt2[c*3 +: 3]}; odr = drop2[c*2 +: 2]; end
        endcase
        sz = mq[i][c].size();
        chk($sformatf("u%0d_ch%0d_pndng", i, c), 32'(op), 32'(sz != 0));
        chk($sformatf("u%0d_ch%0d_full", i, c), 32'(of), 32'(sz == depth[i]));
        chk($sformatf("u%0d_ch%0d_count", i, c), 32'(oc), 32'(sz));
        chk($sformatf("u%0d_ch%0d_dpop", i, c), 32'(od), (sz != 0) ? 32'(mq[i][c][0]) : 32'h0);
        chk($sformatf("u%0d_ch%0d_drop", i, c), 32'(odr), 32'(md[i][c]));
      end
  endtask

  task automatic step(input logic [NCH-1:0] p, input logic [NCH-1:0] q, input logic [NCH*PW-1:0] d);
    push = p;
    pop = q;
    d_push = d;
    @(posedge clk);
    model_edge(p, q, d);
    #1;
    push = '0;
    pop = '0;
    check_all();
  endtask

  function automatic logic [NCH*PW-1:0] slot(input int c, input logic [15:0] v);
    logic [NCH*PW-1:0] r;
    r = '0;
    r[c*PW +: PW] = v;
    return r;
  endfunction

  initial begin
    model_reset();
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all();
    reset = 1'b0;

    // Basic ordering on ch0
    for (int k = 1; k <= 5; k++) step(8'h01, 8'h00, slot(0, 16'(k)));
    chk("basic_cnt5", 32'(cnt0[3:0]), 32'd5);
    for (int k = 1; k <= 5; k++) begin
      chk("basic_head", 32'(dpop0[15:0]), 32'(k));
      step(8'h00, 8'h01, '0);
    end
    chk("basic_empty", 32'(pnd0[0]), 32'd0);

    // Full handling on ch3
    for (int k = 0; k < 10; k++) step(8'h08, 8'h00, slot(3, 16'hA000 + 16'(k)));
    chk("ovf_drop_u0", 32'(drop0[7:6]), 32'd2);
    chk("ovf_drop_u1", 32'(drop1[7:6]), 32'd2);
    chk("ovf_drop_u2_sat", 32'(drop2[7:6]), 32'd3);
    chk("ovf_head_u0", 32'(dpop0[63:48]), 32'hA000);
    chk("ovf_head_u1", 32'(dpop1[63:48]), 32'hA002);
    chk("ovf_head_u2", 32'(dpop2[63:48]), 32'hA005);
    for (int k = 0; k < 8; k++) step(8'h00, 8'h08, '0);

    // Simultaneous push/pop corner cases on ch1
    step(8'h02, 8'h02, slot(1, 16'h1100));
    chk("pp_empty_cnt", 32'(cnt0[7:4]), 32'd1);
    for (int k = 1; k < 8; k++) step(8'h02, 8'h00, slot(1, 16'h1100 + 16'(k)));
    step(8'h02, 8'h02, slot(1, 16'h11FF));
    chk("pp_full_cnt", 32'(cnt0[7:4]), 32'd8);
    chk("pp_full_head", 32'(dpop0[31:16]), 32'h1101);
    chk("pp_full_nodrop", 32'(drop0[3:2]), 32'd0);
    for (int k = 0; k < 10; k++) step(8'h00, 8'h02, '0);
    chk("pop_empty_cnt", 32'(cnt0[7:4]), 32'd0);

    // Saturation on ch5
    for (int k = 0; k < 14; k++) step(8'h20, 8'h00, slot(5, 16'h5500 + 16'(k)));
    chk("sat_drop_u0", 32'(drop0[11:10]), 32'd3);

    // Async reset between edges on ch0
    for (int k = 0; k < 4; k++) step(8'h01, 8'h00, slot(0, 16'hC000 + 16'(k)));
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    chk("rst_dpop0", 32'(dpop0[15:0]), 32'h0);
    #1 reset = 1'b0;
    step(8'h01, 8'h00, slot(0, 16'hBEEF));
    chk("rst_beef", 32'(dpop0[15:0]), 32'hBEEF);
    chk("rst_beef_cnt", 32'(cnt0[3:0]), 32'd1);

    // Randomized traffic: push-heavy then pop-heavy
    for (int k = 0; k < 300; k++) begin
      logic [NCH-1:0] p, q;
      logic [NCH*PW-1:0] d;
      for (int w = 0; w < NCH*PW/32; w++) d[w*32 +: 32] = $urandom();
      if (k < 150) begin
        p = 8'($urandom() | $urandom());
        q = 8'($urandom() & $urandom());
      end else begin
        p = 8'($urandom() & $urandom());
        q = 8'($urandom() | $urandom());
      end
      step(p, q, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
